// File: rtl/rat_intr_pkg.sv
// Shared types for the RAT interrupt/flag shadow logic.
package rat_intr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } intr_state_t;

    typedef struct packed {
        logic c;
        logic z;
    } flag_pair_t;

endpackage

// File: rtl/intr_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, followed by a rising-edge pulse.
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/intr_flag_shadow.sv
// Interrupt request/ack sequencing with a LIFO shadow of the C/Z flags,
// restored on RETIE.
module intr_flag_shadow
    import rat_intr_pkg::*;
#(
    parameter int  SYNC_STAGES = 2,
    parameter int  DEPTH       = 4,
    localparam int DW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          intr_in,
    input  logic          i_set,
    input  logic          i_clr,
    input  logic          c_flag,
    input  logic          z_flag,
    input  logic          fetch_boundary,
    input  logic          intr_ack,
    input  logic          retie,
    output logic          intr_req,
    output logic          flg_restore,
    output logic          c_restore,
    output logic          z_restore,
    output logic          i_flag,
    output logic [DW-1:0] depth,
    output logic          overflow,
    output logic          underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    intr_state_t   r_state, w_state_nxt;
    logic          r_pending, r_i_flag, w_iflag_nxt;
    logic          w_edge, w_accept;
    flag_pair_t    r_stack [DEPTH];
    logic [DW-1:0] r_depth;
    flag_pair_t    r_restore, w_top, w_push;
    logic          r_flg_restore, r_overflow, r_underflow;
    logic          w_empty, w_full;
    logic [AW-1:0] w_top_idx, w_wr_idx;

    intr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(intr_in),
        .o_rise (w_edge)
    );

    assign w_empty   = (r_depth == '0);
    assign w_full    = (r_depth == DW'(DEPTH));
    assign w_top_idx = AW'(r_depth - 1'b1);
    assign w_wr_idx  = AW'(r_depth);
    // Popping an empty stack yields zeros rather than stale contents.
    assign w_top     = w_empty ? flag_pair_t'('0) : r_stack[w_top_idx];
    assign w_push    = '{c: c_flag, z: z_flag};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: if (r_pending && r_i_flag && fetch_boundary) w_state_nxt = REQ;
            REQ: begin
                if (intr_ack) begin
                    w_accept    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (i_clr) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Clearing sources (accept, CLI) dominate setting sources (SEI, RETIE).
    always_comb begin
        w_iflag_nxt = r_i_flag;
        if (w_accept || i_clr)  w_iflag_nxt = 1'b0;
        else if (i_set || retie) w_iflag_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_i_flag  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_edge | (r_pending & ~w_accept);
            r_i_flag  <= w_iflag_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
            r_depth       <= '0;
            r_restore     <= '0;
            r_flg_restore <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_flg_restore <= retie;
            r_restore     <= retie ? w_top : flag_pair_t'('0);
            if (w_accept && retie) begin
                // Pop then push: the top slot is read out and overwritten in place.
                if (w_empty) begin
                    r_stack[w_wr_idx] <= w_push;
                    r_depth           <= DW'(1);
                    r_underflow       <= 1'b1;
                end else begin
                    r_stack[w_top_idx] <= w_push;
                end
            end else if (w_accept) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_stack[w_wr_idx] <= w_push;
                    r_depth           <= r_depth + 1'b1;
                end
            end else if (retie) begin
                if (w_empty) r_underflow <= 1'b1;
                else         r_depth     <= r_depth - 1'b1;
            end
        end
    end

    assign intr_req    = (r_state == REQ);
    assign flg_restore = r_flg_restore;
    assign c_restore   = r_restore.c;
    assign z_restore   = r_restore.z;
    assign i_flag      = r_i_flag;
    assign depth       = r_depth;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_intr_flag_shadow.sv
// Directed bench for intr_flag_shadow: vector table plus nesting, push/pop and reset sequences.
module tb_intr_flag_shadow;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       intr_in, i_set, i_clr, c_flag, z_flag, fetch_boundary, intr_ack, retie;
    logic       intr_req, flg_restore, c_restore, z_restore, i_flag, overflow, underflow;
    logic [2:0] depth;
    logic [9:0] w_out;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] in;   // {intr_in,i_set,i_clr,c,z,fetch_boundary,intr_ack,retie}
        logic [9:0] exp;  // {req,flg_restore,c_r,z_r,i_flag,depth[2:0],ovf,unf}
    } vec_t;
    vec_t vec [25];

    intr_flag_shadow #(.SYNC_STAGES(2), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .intr_in(intr_in), .i_set(i_set), .i_clr(i_clr),
        .c_flag(c_flag), .z_flag(z_flag), .fetch_boundary(fetch_boundary),
        .intr_ack(intr_ack), .retie(retie), .intr_req(intr_req),
        .flg_restore(flg_restore), .c_restore(c_restore), .z_restore(z_restore),
        .i_flag(i_flag), .depth(depth), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    assign w_out = {intr_req, flg_restore, c_restore, z_restore, i_flag, depth, overflow, underflow};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        {intr_in, i_set, i_clr, c_flag, z_flag, fetch_boundary, intr_ack, retie} = '0;
    endtask

    // SEI, raise intr_in at a fetch boundary, and wait (bounded) for the request.
    task automatic raise_and_wait(input string nm);
        logic seen;
        seen  = 1'b0;
        i_set = 1'b1;
        step();
        i_set          = 1'b0;
        intr_in        = 1'b1;
        fetch_boundary = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            if (intr_req) begin
                seen = 1'b1;
                break;
            end
        end
        fetch_boundary = 1'b0;
        chk(nm, {9'b0, seen}, 10'd1);
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int t = 0; t < n; t++) step();
    endtask

    logic [1:0] vals [5];

    initial begin
        // basic service
        vec[0]  = '{8'b01000000, 10'b0000100000};
        vec[1]  = '{8'b10000100, 10'b0000100000};
        vec[2]  = '{8'b10000100, 10'b0000100000};
        vec[3]  = '{8'b10000100, 10'b0000100000};
        vec[4]  = '{8'b10000100, 10'b1000100000};
        vec[5]  = '{8'b10010010, 10'b0000000100};
        vec[6]  = '{8'b00000001, 10'b0110100000};
        vec[7]  = '{8'b00000000, 10'b0000100000};
        // masked pending, then SEI and a later boundary
        vec[8]  = '{8'b00100000, 10'b0000000000};
        vec[9]  = '{8'b10000100, 10'b0000000000};
        vec[10] = '{8'b10000100, 10'b0000000000};
        vec[11] = '{8'b10000100, 10'b0000000000};
        vec[12] = '{8'b10000100, 10'b0000000000};
        vec[13] = '{8'b11000000, 10'b0000100000};
        vec[14] = '{8'b10000000, 10'b0000100000};
        vec[15] = '{8'b10000100, 10'b1000100000};
        // CLI during REQ, re-request, single push
        vec[16] = '{8'b10100000, 10'b0000000000};
        vec[17] = '{8'b11000100, 10'b0000100000};
        vec[18] = '{8'b10000100, 10'b1000100000};
        vec[19] = '{8'b10001010, 10'b0000000100};
        vec[20] = '{8'b10000000, 10'b0000000100};
        vec[21] = '{8'b11000100, 10'b0000100100};
        vec[22] = '{8'b10000100, 10'b0000100100};
        vec[23] = '{8'b00000001, 10'b0101100000};
        vec[24] = '{8'b00000000, 10'b0000100000};

        vals[0] = 2'b00; vals[1] = 2'b01; vals[2] = 2'b10; vals[3] = 2'b11; vals[4] = 2'b10;

        clear_inputs();
        rst_n = 1'b0;
        #12;
        chk("reset_state", w_out, 10'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 25; i++) begin
            {intr_in, i_set, i_clr, c_flag, z_flag, fetch_boundary, intr_ack, retie} = vec[i].in;
            step();
            chk($sformatf("vec%0d", i), w_out, vec[i].exp);
        end
        idle(3);

        // nesting to overflow
        for (int k = 0; k < 5; k++) begin
            raise_and_wait($sformatf("nest_req%0d", k));
            {c_flag, z_flag} = vals[k];
            intr_ack = 1'b1;
            step();
            chk($sformatf("nest_ack%0d", k), w_out,
                {5'b00000, (k < 4) ? 3'(k + 1) : 3'd4, (k == 4) ? 1'b1 : 1'b0, 1'b0});
            idle(3);
        end

        // back-to-back RETIEs in LIFO order, then underflow
        retie = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("pop%0d", j), w_out, {2'b01, vals[3-j], 1'b1, 3'(3 - j), 2'b10});
        end
        step();
        chk("pop_underflow", w_out, 10'b0100100011);
        idle(1);
        chk("pop_idle", w_out, 10'b0000100011);
        idle(2);

        // simultaneous push and pop
        raise_and_wait("pp_req0");
        {c_flag, z_flag} = 2'b11;
        intr_ack = 1'b1;
        step();
        chk("pp_first_push", w_out, 10'b0000000111);
        idle(3);
        raise_and_wait("pp_req1");
        {c_flag, z_flag} = 2'b01;
        intr_ack = 1'b1;
        retie    = 1'b1;
        step();
        chk("pp_same_cycle", w_out, 10'b0111000111);
        clear_inputs();
        retie = 1'b1;
        step();
        chk("pp_new_top", w_out, 10'b0101100011);
        idle(3);

        // asynchronous reset while requesting
        raise_and_wait("rst_req");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", w_out, 10'b0);
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
        i_set = 1'b1;
        step();
        chk("post_reset_sei", w_out, 10'b0000100000);
        i_set          = 1'b0;
        fetch_boundary = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            chk($sformatf("post_reset_idle%0d", t), w_out, 10'b0000100000);
        end
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
